// File: rtl/cve2_obi_sram_responder.sv
// Byte-writable single-port word SRAM behind a req/gnt/rvalid handshake.
// Fixed-latency in-order responses, bounded outstanding count, range error.
module cve2_obi_sram_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(MemWords);

  logic [31:0]            mem [MemWords];
  logic [31:0]            offset;
  logic [IdxW-1:0]        word_idx;
  logic                   hit;
  logic                   accept;
  logic                   rsp_issue;
  logic [2:0]             outstanding_q;
  logic [RespLatency-1:0] pipe_valid_q;
  logic [RespLatency-1:0] pipe_err_q;
  logic [RespLatency-1:0] pipe_read_q;
  logic [31:0]            pipe_data_q [RespLatency];
  logic                   unused_offset_lsb;

  assign offset            = addr_i - BaseAddr;
  assign word_idx          = offset[IdxW+1:2];
  assign hit               = (offset[31:IdxW+2] == '0);
  assign unused_offset_lsb = ^offset[1:0];

  assign gnt_o  = rst_ni & req_i & ~stall_i & (outstanding_q < 3'(MaxOutstanding));
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk_i) begin
    if (accept && we_i && hit) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (be_i[n]) mem[word_idx][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      pipe_read_q  <= '0;
      for (int unsigned i = 0; i < RespLatency; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= accept;
      pipe_err_q[0]   <= accept & ~hit;
      pipe_read_q[0]  <= accept & hit & ~we_i;
      pipe_data_q[0]  <= mem[word_idx];
      for (int unsigned i = 1; i < RespLatency; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_read_q[i]  <= pipe_read_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

  // A slot is released on the edge that raises rvalid_o, so a response being
  // presented no longer blocks a new grant (gives the 1,1,0 grant cadence).
  if (RespLatency == 1) begin : g_issue_lat1
    assign rsp_issue = accept;
  end else begin : g_issue_latn
    assign rsp_issue = pipe_valid_q[RespLatency-2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
    end else if (accept && !rsp_issue) begin
      outstanding_q <= outstanding_q + 3'd1;
    end else if (!accept && rsp_issue) begin
      outstanding_q <= outstanding_q - 3'd1;
    end
  end

  assign rvalid_o = pipe_valid_q[RespLatency-1];
  assign err_o    = pipe_err_q[RespLatency-1];
  assign rdata_o  = pipe_read_q[RespLatency-1] ? pipe_data_q[RespLatency-1] : '0;

endmodule

// File: tb/tb_cve2_obi_sram_responder.sv
// Directed bench: DUT a (latency 1, base 0) and DUT b (latency 3, two
// outstanding, base 0x1000) share stimulus; sel chooses whose outputs are checked.
module tb_cve2_obi_sram_responder;

  localparam logic [31:0] D0 = 32'hC0DE_0000;
  localparam logic [31:0] D1 = 32'hC0DE_0001;
  localparam logic [31:0] D2 = 32'hC0DE_0002;
  localparam logic [31:0] D3 = 32'hC0DE_0003;
  localparam logic [31:0] K0 = 32'h0000_1000;
  localparam logic [31:0] K1 = 32'h0000_1004;
  localparam logic [31:0] K2 = 32'h0000_1008;
  localparam logic [31:0] K3 = 32'h0000_100C;

  logic        clk, rst_ni;
  logic        req, we, stall;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        sel;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  int          errors = 0;
  int          checks = 0;

  cve2_obi_sram_responder #(
    .MemWords(1024), .BaseAddr(32'h0000_0000), .RespLatency(1), .MaxOutstanding(2)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
    .gnt_o(a_gnt), .rvalid_o(a_rvalid), .rdata_o(a_rdata), .err_o(a_err)
  );

  cve2_obi_sram_responder #(
    .MemWords(1024), .BaseAddr(32'h0000_1000), .RespLatency(3), .MaxOutstanding(2)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
    .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .err_o(b_err)
  );

  assign gnt    = sel ? b_gnt    : a_gnt;
  assign rvalid = sel ? b_rvalid : a_rvalid;
  assign err    = sel ? b_err    : a_err;
  assign rdata  = sel ? b_rdata  : a_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, then compare grant and the response being presented.
  task automatic step(input string tag, input logic rq, input logic st, input logic w,
                      input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                      input logic eg, input logic erv, input logic eerr,
                      input logic [31:0] erd);
    @(negedge clk);
    req = rq; stall = st; we = w; be = b; addr = a; wdata = d;
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".rvalid"}, 32'(rvalid), 32'(erv));
    check({tag, ".err"}, 32'(err), 32'(eerr));
    check({tag, ".rdata"}, rdata, erd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0; req = 1'b0; stall = 1'b0;
    #1;
    check("rst.rvalid", 32'(rvalid), 0);
    check("rst.rdata", rdata, 0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; rst_ni = 1'b0; req = 1'b1; stall = 1'b0;
    we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    #2;
    check("init.a.gnt", 32'(a_gnt), 0);
    check("init.a.rvalid", 32'(a_rvalid), 0);
    check("init.a.err", 32'(a_err), 0);
    check("init.a.rdata", a_rdata, 0);
    check("init.b.gnt", 32'(b_gnt), 0);
    check("init.b.rvalid", 32'(b_rvalid), 0);
    req = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;

    // latency 1 write then read
    step("t1.c0", 1, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 0, 0, 0);
    step("t1.c1", 1, 0, 0, 4'hF, 32'h10, 32'h0,        1, 1, 0, 0);
    step("t1.c2", 0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 1, 0, 32'hDEADBEEF);
    step("t1.c3", 0, 0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 0);

    // byte lanes and empty byte enable
    step("t2.c0", 1, 0, 1, 4'hF,    32'h20, 32'h11223344, 1, 0, 0, 0);
    step("t2.c1", 1, 0, 1, 4'b0101, 32'h20, 32'hAABBCCDD, 1, 1, 0, 0);
    step("t2.c2", 1, 0, 0, 4'hF,    32'h20, 32'h0,        1, 1, 0, 0);
    step("t2.c3", 1, 0, 1, 4'h0,    32'h20, 32'hFFFFFFFF, 1, 1, 0, 32'h11BB33DD);
    step("t2.c4", 1, 0, 0, 4'hF,    32'h20, 32'h0,        1, 1, 0, 0);
    step("t2.c5", 0, 0, 0, 4'h0,    32'h0,  32'h0,        0, 1, 0, 32'h11BB33DD);
    step("t2.c6", 0, 0, 0, 4'h0,    32'h0,  32'h0,        0, 0, 0, 0);

    sel = 1'b1;
    do_reset();

    // range limits on the offset-based DUT
    step("t3.c0", 1, 0, 0, 4'hF, 32'h0FFC, 32'h0,       1, 0, 0, 0);
    step("t3.c1", 1, 0, 0, 4'hF, 32'h2000, 32'h0,       1, 0, 0, 0);
    step("t3.c2", 0, 0, 0, 4'h0, 32'h0,    32'h0,       0, 0, 0, 0);
    step("t3.c3", 1, 0, 1, 4'hF, 32'h1FFC, 32'h12345678, 1, 1, 1, 0);
    step("t3.c4", 1, 0, 0, 4'hF, 32'h1FFC, 32'h0,       1, 1, 1, 0);
    step("t3.c5", 0, 0, 0, 4'h0, 32'h0,    32'h0,       0, 0, 0, 0);
    step("t3.c6", 0, 0, 0, 4'h0, 32'h0,    32'h0,       0, 1, 0, 0);
    step("t3.c7", 0, 0, 0, 4'h0, 32'h0,    32'h0,       0, 1, 0, 32'h12345678);
    step("t3.c8", 0, 0, 0, 4'h0, 32'h0,    32'h0,       0, 0, 0, 0);

    // preload four distinct words for ordering checks
    step("pl.c0", 1, 0, 1, 4'hF, K0, D0, 1, 0, 0, 0);
    step("pl.c1", 1, 0, 1, 4'hF, K1, D1, 1, 0, 0, 0);
    step("pl.c2", 0, 0, 0, 4'h0, 0,  0,  0, 0, 0, 0);
    step("pl.c3", 1, 0, 1, 4'hF, K2, D2, 1, 1, 0, 0);
    step("pl.c4", 1, 0, 1, 4'hF, K3, D3, 1, 1, 0, 0);
    step("pl.c5", 0, 0, 0, 4'h0, 0,  0,  0, 0, 0, 0);
    step("pl.c6", 0, 0, 0, 4'h0, 0,  0,  0, 1, 0, 0);
    step("pl.c7", 0, 0, 0, 4'h0, 0,  0,  0, 1, 0, 0);
    step("pl.c8", 0, 0, 0, 4'h0, 0,  0,  0, 0, 0, 0);

    do_reset();

    // req held high: grant cadence 1,1,0 and in-order read data
    step("t4.c0",  1, 0, 0, 4'hF, K0, 0, 1, 0, 0, 0);
    step("t4.c1",  1, 0, 0, 4'hF, K1, 0, 1, 0, 0, 0);
    step("t4.c2",  1, 0, 0, 4'hF, K2, 0, 0, 0, 0, 0);
    step("t4.c3",  1, 0, 0, 4'hF, K2, 0, 1, 1, 0, D0);
    step("t4.c4",  1, 0, 0, 4'hF, K3, 0, 1, 1, 0, D1);
    step("t4.c5",  1, 0, 0, 4'hF, K0, 0, 0, 0, 0, 0);
    step("t4.c6",  1, 0, 0, 4'hF, K0, 0, 1, 1, 0, D2);
    step("t4.c7",  1, 0, 0, 4'hF, K1, 0, 1, 1, 0, D3);
    step("t4.c8",  1, 0, 0, 4'hF, K2, 0, 0, 0, 0, 0);
    step("t4.c9",  1, 0, 0, 4'hF, K2, 0, 1, 1, 0, D0);
    step("t4.c10", 1, 0, 0, 4'hF, K3, 0, 1, 1, 0, D1);
    step("t4.c11", 0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);
    step("t4.c12", 0, 0, 0, 4'h0, 0,  0, 0, 1, 0, D2);
    step("t4.c13", 0, 0, 0, 4'h0, 0,  0, 0, 1, 0, D3);
    step("t4.c14", 0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);

    do_reset();

    // stall blocks grants only; in-flight read completes on schedule
    step("t5.c0",  1, 0, 0, 4'hF, K0, 0, 1, 0, 0, 0);
    step("t5.c1",  1, 1, 0, 4'hF, K1, 0, 0, 0, 0, 0);
    step("t5.c2",  1, 1, 0, 4'hF, K1, 0, 0, 0, 0, 0);
    step("t5.c3",  1, 1, 0, 4'hF, K1, 0, 0, 1, 0, D0);
    step("t5.c4",  1, 1, 0, 4'hF, K1, 0, 0, 0, 0, 0);
    step("t5.c5",  1, 1, 0, 4'hF, K1, 0, 0, 0, 0, 0);
    step("t5.c6",  1, 0, 0, 4'hF, K1, 0, 1, 0, 0, 0);
    step("t5.c7",  0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);
    step("t5.c8",  0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);
    step("t5.c9",  0, 0, 0, 4'h0, 0,  0, 0, 1, 0, D1);
    step("t5.c10", 0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);

    do_reset();

    // reset with two accepts in flight; the pre-reset write must persist
    step("t6.c0", 1, 0, 0, 4'hF, K0, 0,            1, 0, 0, 0);
    step("t6.c1", 1, 0, 1, 4'hF, K1, 32'h5A5A5A5A, 1, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b0; req = 1'b1; we = 1'b0; addr = K2;
    #1;
    check("t6.rst0.gnt", 32'(gnt), 0);
    check("t6.rst0.rvalid", 32'(rvalid), 0);
    @(negedge clk);
    #1;
    check("t6.rst1.gnt", 32'(gnt), 0);
    check("t6.rst1.rvalid", 32'(rvalid), 0);
    rst_ni = 1'b1; req = 1'b0;
    step("t6.p0", 1, 0, 0, 4'hF, K1, 0, 1, 0, 0, 0);
    step("t6.p1", 0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);
    step("t6.p2", 0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);
    step("t6.p3", 0, 0, 0, 4'h0, 0,  0, 0, 1, 0, 32'h5A5A5A5A);
    step("t6.p4", 0, 0, 0, 4'h0, 0,  0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
